// File: rtl/piso_tx_pkg_amisha.sv
// Shared types and helpers for the framed PISO transmitter.
// Optional parity stage is controlled by the PISO_TX_PARITY_EN macro.
package piso_tx_pkg_amisha;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Cycles from start bit to stop bit inclusive.
  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    return width + (parity_en ? 32'd3 : 32'd2);
  endfunction

endpackage

// File: rtl/shift_reg_load_amisha.sv
// Loadable WIDTH-bit shift register; bit_o is the next bit to go on the line.
module shift_reg_load_amisha #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] sr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      else           sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_serial_tx_amisha.sv
// Framed parallel-in serial-out transmitter: start, WIDTH data bits, [parity], stop.
// Define PISO_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module piso_serial_tx_amisha
  import piso_tx_pkg_amisha::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk_amisha,
  input  logic             reset_n_amisha,
  input  logic [WIDTH-1:0] data_in_amisha,
  input  logic             valid_in_amisha,
  output logic             ready_out_amisha,
  output logic             sout_amisha,
  output logic             busy_amisha,
  output logic             done_amisha
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          sout_q;
  logic          done_q;
  logic          xfer;
  logic          shift_en;
  logic          cur_bit;

  // STOP accepts a new word so frames can run back-to-back without an idle gap.
  assign ready_out_amisha = (state_q == ST_IDLE) || (state_q == ST_STOP);
  assign xfer             = valid_in_amisha & ready_out_amisha;
  assign shift_en         = (state_q == ST_START) || ((state_q == ST_DATA) && (cnt_q != LAST));

  shift_reg_load_amisha #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk_amisha),
    .rst_n   (reset_n_amisha),
    .load_i  (xfer),
    .shift_i (shift_en),
    .data_i  (data_in_amisha),
    .bit_o   (cur_bit)
  );

`ifdef PISO_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) parity_q <= 1'b0;
    else if (xfer)       parity_q <= ^data_in_amisha;
  end
`endif

  // Line value is registered: each branch sets what sout shows in the next state.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sout_q  <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_STOP: begin
          if (xfer) begin
            state_q <= ST_START;
            sout_q  <= ~IDLE_LEVEL;
          end else begin
            state_q <= ST_IDLE;
            sout_q  <= IDLE_LEVEL;
          end
        end
        ST_START: begin
          state_q <= ST_DATA;
          cnt_q   <= '0;
          sout_q  <= cur_bit;
        end
        ST_DATA: begin
          if (cnt_q == LAST) begin
`ifdef PISO_TX_PARITY_EN
            state_q <= ST_PARITY;
            sout_q  <= parity_q;
`else
            state_q <= ST_STOP;
            sout_q  <= IDLE_LEVEL;
            done_q  <= 1'b1;
`endif
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            sout_q <= cur_bit;
          end
        end
`ifdef PISO_TX_PARITY_EN
        ST_PARITY: begin
          state_q <= ST_STOP;
          sout_q  <= IDLE_LEVEL;
          done_q  <= 1'b1;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          sout_q  <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign sout_amisha = sout_q;
  assign done_amisha = done_q;
  assign busy_amisha = (state_q != ST_IDLE);

endmodule
